// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: signed max and pooled-row sizing.
package cnn_pkg;

    // Wide enough for any sample width the accelerator uses; callers sign-extend into it.
    localparam int MAX_S_W = 64;

    typedef logic signed [MAX_S_W-1:0] max_s_t;

    function automatic max_s_t max_s(input max_s_t a, input max_s_t b);
        return (a >= b) ? a : b;
    endfunction

    function automatic int POOL_OUT_W(input int img_width);
        return img_width / 2;
    endfunction

endpackage

// File: rtl/relu_maxpool_stream_if.sv
// Ready/valid sample stream in and pooled result stream out for the max-pool stage.
interface relu_maxpool_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pool_row_buf.sv
// One pooled row of horizontal pair maxima: single write port, combinational read.
module pool_row_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 13,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk_i,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_waddr,
    input  logic signed [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]                i_raddr,
    output logic signed [DATA_WIDTH-1:0] o_rdata
);
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/relu_maxpool_stream.sv
// Streaming 2x2 stride-2 max-pool over a row-major ReLU sample stream.
// Even rows fill the row buffer with pair maxima; odd rows finish each window.
module relu_maxpool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 26,
    parameter int IMG_HEIGHT = 26
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    relu_maxpool_stream_if.slave s_if,
    output logic                 frame_done_o
);
    localparam int HALF_W = POOL_OUT_W(IMG_WIDTH);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [CW-1:0]                r_col;
    logic [RW-1:0]                r_row;
    logic signed [DATA_WIDTH-1:0] r_pair;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_out_valid;
    logic                         r_frame_done;

    logic                         w_accept;
    logic                         w_col_last;
    logic                         w_row_last;
    logic                         w_buf_we;
    logic                         w_load;
    logic [AW-1:0]                w_idx;
    logic signed [DATA_WIDTH-1:0] w_hmax;
    logic signed [DATA_WIDTH-1:0] w_vmax;
    logic signed [DATA_WIDTH-1:0] w_buf_rd;

    // Stalls on any held result, even if the next sample would not produce one.
    assign s_if.in_ready = !clear_i && (!r_out_valid || s_if.out_ready);
    assign w_accept      = s_if.in_valid && s_if.in_ready;
    assign w_col_last    = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last    = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_idx         = AW'(r_col >> 1);

    // Odd width/height: trailing column is even and trailing row is even, so they never pool.
    assign w_buf_we = w_accept && r_col[0] && !r_row[0];
    assign w_load   = w_accept && r_col[0] && r_row[0];

    assign w_hmax = DATA_WIDTH'(max_s(max_s_t'(r_pair), max_s_t'(s_if.in_data)));
    assign w_vmax = DATA_WIDTH'(max_s(max_s_t'(w_buf_rd), max_s_t'(w_hmax)));

    pool_row_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (HALF_W)
    ) u_row_buf (
        .clk_i  (clk_i),
        .i_we   (w_buf_we),
        .i_waddr(w_idx),
        .i_wdata(w_hmax),
        .i_raddr(w_idx),
        .o_rdata(w_buf_rd)
    );

    // Stage boundary: counters, pair register and the output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_col        <= '0;
            r_row        <= '0;
            r_pair       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (clear_i) begin
                r_col       <= '0;
                r_row       <= '0;
                r_pair      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (!r_col[0]) begin
                        r_pair <= s_if.in_data;
                    end
                end
                if (w_load) begin
                    r_out_data  <= w_vmax;
                    r_out_valid <= 1'b1;
                end else if (s_if.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign s_if.out_data  = r_out_data;
    assign s_if.out_valid = r_out_valid;
    assign frame_done_o   = r_frame_done;
endmodule
